// File: rtl/if_fetch.sv
// Instruction fetch stage: SRAM-like bus master with a 2-entry PC queue and 2-entry output FIFO.
// Optional misaligned-PC detection is compiled in with `define IF_ADDR_ERR_EN.
module if_fetch #(
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_i,
  output logic        wpc,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        id_allowin,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_adel,
  output logic        state_dbg
);
  // Handshakes: a request transfers when inst_req & inst_addr_ok at posedge, a response when
  // inst_data_ok (in request order), an instruction leaves when if_valid & id_allowin & !flush.
  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;
  state_t state, state_nxt;

  logic [1:0]  inflight, discard, buf_cnt;
  logic [31:0] pcq [2];
  logic        pcq_wr, pcq_rd;
  logic [31:0] fifo_pc [2];
  logic [31:0] fifo_inst [2];
  logic        fifo_wr, fifo_rd;
  logic        blocked, launch, launch_bus, launch_err;
  logic        accept, resp, resp_keep, push, pop;
  logic [31:0] push_pc, push_inst;

  // Credit covers both outstanding requests and buffered words, so the FIFO cannot overflow.
  assign launch    = (state == S_IDLE) && !flush && !blocked &&
                     (({1'b0, inflight} + {1'b0, buf_cnt}) < 3'd2);
  assign accept    = (state == S_REQ) && inst_addr_ok;
  assign wpc       = accept;
  assign inst_req  = (state == S_REQ);
  assign state_dbg = (state == S_REQ);
  assign resp      = inst_data_ok && (inflight != 2'd0);
  assign resp_keep = resp && (discard == 2'd0) && !flush;
  assign push      = resp_keep || launch_err;
  assign push_pc   = resp_keep ? pcq[pcq_rd] : PC_i;
  assign push_inst = resp_keep ? inst_rdata : NOP_INST;
  assign if_valid  = (buf_cnt != 2'd0);
  assign pop       = if_valid && id_allowin && !flush;
  assign if_inst   = if_valid ? fifo_inst[fifo_rd] : NOP_INST;
  assign if_pc     = if_valid ? fifo_pc[fifo_rd] : 32'h0;

`ifdef IF_ADDR_ERR_EN
  logic err_block;
  logic fifo_adel [2];
  // A misaligned PC waits for older fetches to drain so its error entry stays in program order.
  assign launch_bus = launch && (PC_i[1:0] == 2'b00);
  assign launch_err = launch && (PC_i[1:0] != 2'b00) && (inflight == 2'd0);
  assign blocked    = err_block;
  assign if_adel    = if_valid && fifo_adel[fifo_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_block <= 1'b0;
    end else if (flush) begin
      err_block <= 1'b0;
    end else if (launch_err) begin
      err_block <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adel[fifo_wr] <= !resp_keep;
    end
  end
`else
  assign launch_bus = launch;
  assign launch_err = 1'b0;
  assign blocked    = 1'b0;
  assign if_adel    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (launch_bus) state_nxt = S_REQ;
      S_REQ:  if (accept) state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      inst_addr <= 32'h0;
      inflight  <= 2'd0;
      discard   <= 2'd0;
      pcq_wr    <= 1'b0;
      pcq_rd    <= 1'b0;
      buf_cnt   <= 2'd0;
      fifo_wr   <= 1'b0;
      fifo_rd   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch_bus) begin
        inst_addr <= PC_i;
      end
      inflight <= inflight + {1'b0, launch_bus} - {1'b0, resp};
      if (accept) begin
        pcq_wr <= ~pcq_wr;
      end
      if (resp) begin
        pcq_rd <= ~pcq_rd;
      end
      // Everything still on the bus at a flush belongs to the wrong path.
      if (flush) begin
        discard <= inflight - {1'b0, resp};
      end else if (resp && (discard != 2'd0)) begin
        discard <= discard - 2'd1;
      end
      if (flush) begin
        buf_cnt <= 2'd0;
        fifo_wr <= 1'b0;
        fifo_rd <= 1'b0;
      end else begin
        if (push) begin
          fifo_wr <= ~fifo_wr;
        end
        if (pop) begin
          fifo_rd <= ~fifo_rd;
        end
        buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pcq[pcq_wr] <= inst_addr;
    end
    if (push) begin
      fifo_pc[fifo_wr]   <= push_pc;
      fifo_inst[fifo_wr] <= push_inst;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: in-order SRAM-like bus model, PC-register model and scoreboard queue.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk, rst, flush, id_allowin;
  logic [31:0] PC_i, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        wpc, inst_req, if_valid, if_adel, state_dbg;
  logic [31:0] inst_addr, if_inst, if_pc;

  if_fetch #(.NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .PC_i(PC_i), .wpc(wpc), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .id_allowin(id_allowin),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_adel(if_adel),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'hbfc00000) ? 32'h24080001 : (a ^ 32'h12345678);
  endfunction

  typedef struct {logic [31:0] addr; int due;} resp_t;
  resp_t       resp_q[$];
  logic [64:0] exp_q[$];  // {pc, inst, adel}

  int          cyc = 0, wait_cnt = 0, aok_dly = 0, dok_dly = 1;
  int          n_wpc = 0, n_pop = 0, n_stale = 0, last_rst_cyc = 0, fv_cyc = 0;
  logic        stale_pend = 1'b0, hold_valid = 1'b0, first_seen = 1'b0, fv_seen = 1'b0;
  logic [31:0] pc_reg = 32'h0, hold_addr = 32'h0, first_pc = 32'h0, first_inst = 32'h0;

  // Bus slave and PC register drive on the falling edge.
  always @(negedge clk) begin
    inst_addr_ok = !rst && inst_req && (wait_cnt >= aok_dly);
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hdeadbeef;
    if (!rst && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      inst_data_ok = 1'b1;
      inst_rdata   = mem_word(resp_q[0].addr);
    end
    PC_i = pc_reg;
  end

  // Monitor and scoreboard, sampled just before each rising edge.
  initial forever begin
    logic [64:0] e;
    @(negedge clk);
    #4;
    if (rst) begin
      exp_q.delete();
      resp_q.delete();
      wait_cnt = 0; stale_pend = 1'b0; hold_valid = 1'b0; fv_seen = 1'b0;
      last_rst_cyc = cyc;
    end else begin
      check("wpc_pulse", 32'(wpc), 32'(inst_req && inst_addr_ok));
      if (!if_valid) check("idle_inst", if_inst, NOP);
      if (if_valid && !fv_seen) begin
        fv_seen = 1'b1;
        fv_cyc = cyc;
      end
      if (inst_req) begin
        if (hold_valid) check("addr_stable", inst_addr, hold_addr);
        hold_addr = inst_addr;
        hold_valid = 1'b1;
      end
      if (inst_req && inst_addr_ok) begin
        resp_q.push_back('{inst_addr, cyc + dok_dly});
        hold_valid = 1'b0;
        wait_cnt = 0;
        n_wpc++;
        if (flush || stale_pend) begin
          stale_pend = 1'b0;
          n_stale++;
        end else begin
          check("inst_addr", inst_addr, pc_reg);
          exp_q.push_back({pc_reg, mem_word(pc_reg), 1'b0});
          pc_reg = pc_reg + 32'd4;
        end
      end else if (inst_req) begin
        wait_cnt++;
        if (flush) stale_pend = 1'b1;
      end
      if (inst_data_ok) void'(resp_q.pop_front());
      if (if_valid && id_allowin && !flush) begin
        n_pop++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_pc = if_pc;
          first_inst = if_inst;
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: pc %h inst %h, expected no instruction", if_pc, if_inst);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", if_pc, e[64:33]);
          check("pop_inst", if_inst, e[32:1]);
          check("pop_adel", 32'(if_adel), 32'(e[0]));
        end
      end
      if (flush) exp_q.delete();
    end
    cyc++;
  end

  task automatic do_reset(input logic [31:0] pc);
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; id_allowin = 1'b0;
    pc_reg = pc; PC_i = pc;
    @(negedge clk);
    #2;
    check("rst_inst_req", 32'(inst_req), 32'd0);
    check("rst_wpc", 32'(wpc), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_inst", if_inst, NOP);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_adel", 32'(if_adel), 32'd0);
    check("rst_inst_addr", inst_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n_wpc = 0; n_pop = 0; n_stale = 0; first_seen = 1'b0;
  endtask

  // Caller is at a falling edge; flush lasts one cycle.
  task automatic do_flush(input logic [31:0] tgt);
    flush = 1'b1; pc_reg = tgt; PC_i = tgt; first_seen = 1'b0;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic run_pops(input string name, input int n, input int pct, input int budget);
    int k = 0;
    while (n_pop < n && k < budget) begin
      id_allowin = ($urandom_range(99) < pct);
      @(negedge clk);
      k++;
    end
    id_allowin = 1'b0;
    if (n_pop < n) check(name, 32'(n_pop), 32'(n));
  endtask

  task automatic wait_wpc(input string name, input int n, input int budget);
    int k = 0;
    while (n_wpc < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_wpc < n) check(name, 32'(n_wpc), 32'(n));
  endtask

  typedef struct {
    logic [31:0] pc0; int aok; int dok; int pct; int n_inst;
    logic [31:0] exp_pc; logic [31:0] exp_inst; int exp_lat;
  } vec_t;
  vec_t vecs[4];

  initial begin
    rst = 1'b1; flush = 1'b0; id_allowin = 1'b0; PC_i = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    vecs[0] = '{32'hbfc00000, 0, 2, 100, 1, 32'hbfc00000, 32'h24080001, 4};
    vecs[1] = '{32'h80001000, 1, 1, 100, 6, 32'h80001000, 32'h92344678, 4};
    vecs[2] = '{32'h00400000, 0, 3, 50, 8, 32'h00400000, 32'h12745678, 5};
    vecs[3] = '{32'h80001000, 2, 2, 30, 5, 32'h80001000, 32'h92344678, 6};

    foreach (vecs[v]) begin
      aok_dly = vecs[v].aok;
      dok_dly = vecs[v].dok;
      do_reset(vecs[v].pc0);
      run_pops("vec_timeout", vecs[v].n_inst, vecs[v].pct, 400);
      check("vec_first_pc", first_pc, vecs[v].exp_pc);
      check("vec_first_inst", first_inst, vecs[v].exp_inst);
      check("vec_latency", 32'(fv_cyc - (last_rst_cyc + 1)), 32'(vecs[v].exp_lat));
    end

    // Decode stalled: two fetches fill the FIFO, then fetch stops.
    aok_dly = 0; dok_dly = 1;
    do_reset(32'h80000000);
    repeat (20) @(negedge clk);
    #2;
    check("stall_n_req", 32'(n_wpc), 32'd2);
    check("stall_inst_req", 32'(inst_req), 32'd0);
    check("stall_if_valid", 32'(if_valid), 32'd1);
    check("stall_head_pc", if_pc, 32'h80000000);
    @(negedge clk);
    run_pops("stall_resume", 6, 100, 100);
    check("stall_more_req", 32'(n_wpc > 2), 32'd1);

    // Flush with two requests outstanding: both responses dropped.
    aok_dly = 0; dok_dly = 6;
    do_reset(32'h80000100);
    wait_wpc("flush2_wait", 2, 50);
    id_allowin = 1'b1;
    do_flush(32'h80002000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      check("flush2_no_valid", 32'(if_valid), 32'd0);
    end
    run_pops("flush2_refetch", 2, 100, 100);
    check("flush2_first_pc", first_pc, 32'h80002000);
    check("flush2_first_inst", first_inst, 32'h92347678);

    // Flush while the request waits for acceptance.
    aok_dly = 3; dok_dly = 1;
    do_reset(32'h80000200);
    for (int k = 0; k < 20 && !inst_req; k++) begin
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    do_flush(32'h00400010);
    run_pops("sreq_refetch", 2, 100, 100);
    check("sreq_stale_accepts", 32'(n_stale), 32'd1);
    check("sreq_first_pc", first_pc, 32'h00400010);
    check("sreq_first_inst", first_inst, 32'h12745668);

    // Reset with a request outstanding, then normal fetch.
    aok_dly = 0; dok_dly = 5;
    do_reset(32'h80000300);
    wait_wpc("rstmid_wait", 1, 20);
    do_reset(32'h80000400);
    aok_dly = 1; dok_dly = 1;
    run_pops("rstmid_refetch", 2, 100, 100);
    check("rstmid_first_pc", first_pc, 32'h80000400);

`ifdef IF_ADDR_ERR_EN
    // Misaligned PC: error entry, no bus traffic, held until flush.
    aok_dly = 0; dok_dly = 1;
    do_reset(32'hbfc00002);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      check("adel_inst_req", 32'(inst_req), 32'd0);
    end
    check("adel_n_wpc", 32'(n_wpc), 32'd0);
    check("adel_if_valid", 32'(if_valid), 32'd1);
    check("adel_if_adel", 32'(if_adel), 32'd1);
    check("adel_if_pc", if_pc, 32'hbfc00002);
    check("adel_if_inst", if_inst, NOP);
    @(negedge clk);
    do_flush(32'hbfc00000);
    #2;
    check("adel_cleared", 32'(if_adel), 32'd0);
    run_pops("adel_refetch", 1, 100, 100);
    check("adel_first_inst", first_inst, 32'h24080001);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: NOP_INST, 32'h00000000, value driven on if_inst when if_valid=0.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 PC_i  input  32  current PC from the PC register.
REQ-005 wpc  output  1  PC-register write enable; advances PC.
REQ-006 flush  input  1  branch/exception redirect; discard all fetch state.
REQ-007 inst_req  output  1  instruction-bus request valid (SRAM-like).
REQ-008 inst_addr  output  32  request address.
REQ-009 inst_addr_ok  input  1  request accepted this cycle.
REQ-010 inst_data_ok  input  1  read data returned this cycle, in request order.
REQ-011 inst_rdata  input  32  returned instruction word.
REQ-012 id_allowin  input  1  decode stage accepts an instruction this cycle.
REQ-013 if_valid  output  1  if_inst/if_pc/if_adel valid.
REQ-014 if_inst  output  32  fetched instruction.
REQ-015 if_pc  output  32  PC of if_inst.
REQ-016 if_adel  output  1  address-error flag for this entry.

Function
REQ-017 FSM states S_IDLE (no request presented) and S_REQ (inst_req=1).
REQ-018 S_IDLE->S_REQ when flush=0 and inflight+buf_cnt<2; inst_addr registered from PC_i at that edge; inflight increments.
REQ-019 In S_REQ, inst_req and inst_addr held stable until inst_addr_ok; on inst_addr_ok: wpc=1 same cycle (combinational), inst_addr pushed to 2-entry PC queue, next state S_IDLE.
REQ-020 wpc is 1 only in the cycle inst_req & inst_addr_ok; peak issue rate one request per 2 cycles.
REQ-021 inflight (0..2) decrements on inst_data_ok; simultaneous launch and data_ok leaves it unchanged.
REQ-022 On inst_data_ok with discard=0: pop PC queue head, push {pc, inst_rdata, adel=0} into 2-entry output FIFO.
REQ-023 Output FIFO never overflows: credit rule REQ-018 guarantees space; push and pop in same cycle keep buf_cnt.
REQ-024 if_valid = (buf_cnt!=0); if_inst/if_pc/if_adel show FIFO head; pop when if_valid & id_allowin & !flush.
REQ-025 flush: FIFO cleared, discard <= inflight minus (1 if inst_data_ok same cycle), no launch that cycle.
REQ-026 flush in S_REQ before addr_ok: request held until accepted (bus rule), wpc still pulses, its response counted in discard.
REQ-027 inst_data_ok with discard>0: response dropped, PC queue popped, discard decrements, FIFO unchanged.
REQ-028 Flush with discard>0 reloads discard per REQ-025 (no accumulation beyond inflight).

Reset
REQ-029 rst=1 at posedge: state S_IDLE, inflight=0, discard=0, buf_cnt=0, PC queue empty, inst_addr=0.
REQ-030 During/after reset: inst_req=0, wpc=0, if_valid=0, if_inst=NOP_INST, if_pc=0, if_adel=0.
REQ-031 rst overrides flush and all handshakes; mid-transaction responses after reset are not tracked.

Configuration
REQ-032 Macro IF_ADDR_ERR_EN compiles in misaligned-PC detection.
REQ-033 Defined: launch with PC_i[1:0]!=0 issues no bus request, no wpc; pushes {PC_i, NOP_INST, adel=1} into FIFO; further launches blocked until flush.
REQ-034 Undefined: no check; PC_i used as-is; if_adel constant 0.

Verification
REQ-035 Reset, PC_i=32'hbfc00000, addr_ok next cycle, data_ok 2 cycles later, rdata=32'h24080001, id_allowin=1 -> one wpc pulse, if_valid with if_pc=32'hbfc00000, if_inst=32'h24080001.
REQ-036 id_allowin=0, bus always ready -> exactly 2 requests issued, FIFO full, inst_req stays 0; allowin=1 -> pops in order, fetch resumes.
REQ-037 Two requests outstanding, flush, then 2 data_ok -> both dropped, if_valid stays 0; next fetch delivered normally.
REQ-038 Flush in S_REQ with addr_ok delayed 3 cycles -> inst_addr stable, wpc once on accept, response discarded.
REQ-039 IF_ADDR_ERR_EN, PC_i=32'hbfc00002 -> inst_req=0, wpc=0, if_valid=1, if_adel=1, if_pc=32'hbfc00002 until flush.
REQ-040 rst asserted with one request outstanding -> all outputs at reset values next cycle.
